// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 32-bit logarithmic shifter between the ALU shift path (req0)
// and the load/store align path (req1). Define SHIFT_ARB_PIPE_EN to add an input register stage.

module shift_arbiter_shr #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [SHW-1:0]   i_sha,
  output logic [WIDTH-1:0] o_data
);
  logic [SHW:0][WIDTH-1:0] w_stg;

  assign w_stg[0] = i_data;
  for (genvar k = 0; k < SHW; k++) begin : g_stg
    assign w_stg[k+1] = i_sha[k] ? (w_stg[k] >> (1 << k)) : w_stg[k];
  end
  assign o_data = w_stg[SHW];
endmodule

module shift_arbiter #(
  parameter int WIDTH     = 32,
  parameter bit FIRST_PRI = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [4:0]       req0_sha,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [4:0]       req1_sha,
  input  logic [1:0]       req1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_id
);
  localparam int         SHW    = 5;
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b10;

  logic             r_last_grant;
  logic             r_resp_valid;
  logic [WIDTH-1:0] r_resp_data;
  logic             r_resp_id;

  logic             w_both, w_any, w_pick, w_can_accept, w_grant;
  logic [WIDTH-1:0] w_gnt_data;
  logic [SHW-1:0]   w_gnt_sha;
  logic [1:0]       w_gnt_op;

  logic [WIDTH-1:0] w_op_data;
  logic [SHW-1:0]   w_op_sha;
  logic [1:0]       w_op_kind;
  logic [WIDTH-1:0] w_in_rev, w_net_in, w_net_out, w_out_rev;
  logic [WIDTH-1:0] w_ones_shr, w_sra_fill, w_shift;

  // Arbitration: a lone requester wins; under contention the one not granted last wins.
  assign w_both     = req0_valid & req1_valid;
  assign w_any      = req0_valid | req1_valid;
  assign w_pick     = w_both ? ~r_last_grant : req1_valid;
  assign w_grant    = w_any & w_can_accept & ~reset;
  assign req0_ready = w_grant & ~w_pick;
  assign req1_ready = w_grant &  w_pick;

  assign w_gnt_data = w_pick ? req1_data : req0_data;
  assign w_gnt_sha  = w_pick ? req1_sha  : req0_sha;
  assign w_gnt_op   = w_pick ? req1_op   : req0_op;

  always_ff @(posedge clk) begin
    if (reset)        r_last_grant <= ~FIRST_PRI;
    else if (w_grant) r_last_grant <= w_pick;
  end

  // Left shifts reuse the right-shift network by reversing bits on both sides.
  for (genvar b = 0; b < WIDTH; b++) begin : g_rev
    assign w_in_rev[b]  = w_op_data[WIDTH-1-b];
    assign w_out_rev[b] = w_net_out[WIDTH-1-b];
  end

  assign w_net_in = (w_op_kind == OP_SLL) ? w_in_rev : w_op_data;

  shift_arbiter_shr #(.WIDTH(WIDTH), .SHW(SHW)) u_net (
    .i_data (w_net_in),
    .i_sha  (w_op_sha),
    .o_data (w_net_out)
  );

  // Sign fill mask: the top sha bits, i.e. ~(all-ones >> sha).
  shift_arbiter_shr #(.WIDTH(WIDTH), .SHW(SHW)) u_mask (
    .i_data ({WIDTH{1'b1}}),
    .i_sha  (w_op_sha),
    .o_data (w_ones_shr)
  );

  assign w_sra_fill = w_op_data[WIDTH-1] ? ~w_ones_shr : '0;

  always_comb begin
    w_shift = w_net_out;
    case (w_op_kind)
      OP_SLL:  w_shift = w_out_rev;
      OP_SRA:  w_shift = w_net_out | w_sra_fill;
      default: w_shift = w_net_out;
    endcase
  end

`ifdef SHIFT_ARB_PIPE_EN
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_data;
  logic [SHW-1:0]   r_s1_sha;
  logic [1:0]       r_s1_op;
  logic             r_s1_id;
  logic             w_s1_adv;

  assign w_s1_adv     = r_s1_valid & (~r_resp_valid | resp_ready);
  assign w_can_accept = ~r_s1_valid | w_s1_adv;
  assign w_op_data    = r_s1_data;
  assign w_op_sha     = r_s1_sha;
  assign w_op_kind    = r_s1_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_sha   <= '0;
      r_s1_op    <= '0;
      r_s1_id    <= 1'b0;
    end else if (w_grant) begin
      r_s1_valid <= 1'b1;
      r_s1_data  <= w_gnt_data;
      r_s1_sha   <= w_gnt_sha;
      r_s1_op    <= w_gnt_op;
      r_s1_id    <= w_pick;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_id    <= 1'b0;
    end else if (w_s1_adv) begin
      r_resp_valid <= 1'b1;
      r_resp_data  <= w_shift;
      r_resp_id    <= r_s1_id;
    end else if (resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end
`else
  assign w_can_accept = ~r_resp_valid | resp_ready;
  assign w_op_data    = w_gnt_data;
  assign w_op_sha     = w_gnt_sha;
  assign w_op_kind    = w_gnt_op;

  // Result fields only load on a grant, so a stalled FULL register holds steady.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_id    <= 1'b0;
    end else if (w_grant) begin
      r_resp_valid <= 1'b1;
      r_resp_data  <= w_shift;
      r_resp_id    <= w_pick;
    end else if (resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end
`endif

  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_id    = r_resp_id;
endmodule
